cr_op_seq: RTL and testbench
============================

# cr_op_seq

Multi-cycle sequencer that executes capability-manipulation ops against the CR0..CR3 capability register file. It sits between the execute stage and the register file, owning read port 1 (source CR), read port 2 (key CR) and the single write port. Each accepted op is snapshotted, checked for tag, seal, bounds and permission violations, and then committed as a field-wise write or reported as a fault.

## Interface
Parameters: none. Widths come from `HBIT_ADDR` (47), `HBIT_DATA` (23) and `HBIT_TGT_CR` (1).

- iw_clk  in  1  clock
- iw_rst  in  1  reset, synchronous, active-high
- iw_req  in  1  op request
- ow_ready  out  1  idle, can accept a request
- iw_op  in  3  0 CINC, 1 CSETBOUNDS, 2 CANDPERM, 3 CSEAL, 4 CUNSEAL, 5 CMOVE, 6 CCLRTAG, 7 illegal
- iw_src / iw_key / iw_dst  in  2 each  CR indices
- iw_operand  in  48  signed increment, length, or perm mask (bits [23:0])
- ow_rd_addr1 / ow_rd_addr2  out  2  to register-file read ports (src / key)
- iw_rd1_{base,len,cur}  in  48; iw_rd1_{perms,attr}  in  24; iw_rd1_tag  in  1  (same set for rd2)
- ow_wr_addr  out  2; ow_wr_en_{base,len,cur,perms,attr,tag}  out  1 each; ow_wr_{base,len,cur}  out  48; ow_wr_{perms,attr}  out  24; ow_wr_tag  out  1
- ow_done  out  1  one-cycle completion pulse
- ow_fault  out  1  valid with ow_done
- ow_fault_code  out  3  0 none, 1 tag, 2 sealed, 3 bounds, 4 perm, 5 illegal, 6 otype

## Operation
- Field layout:
  - perms bit4 = SEAL, bit5 = UNSEAL.
  - attr bit0 = sealed, attr[23:8] = otype.
- FSM: IDLE → READ → EXEC → COMMIT → IDLE.
  - IDLE: ow_ready=1. On iw_req, latch op, src, key, dst and operand. Drive the rd addrs from the latches.
  - READ: capture all rd1/rd2 fields into snapshot registers.
  - EXEC: compute results and the fault code from the snapshot only. Register both.
  - COMMIT: ow_done=1. If no fault, assert the op's write enables for this one cycle. Return to IDLE.
- Fault checks, in priority order:
  - src tag=0 → 1. This check is skipped for CMOVE and CCLRTAG.
  - src sealed → 2. This check is skipped for CMOVE, CCLRTAG and CUNSEAL.
  - The op-specific checks below follow.
- CINC:
  - new_cur = cur + operand (48-bit wrap).
  - Fault 3 if new_cur < base or new_cur > base+len, with both compared as 49-bit.
  - Writes cur.
- CSETBOUNDS:
  - Fault 3 if cur < base, or if cur+operand > base+len (49-bit; carry-out = fault).
  - Writes base=cur, len=operand, cur=cur, perms and attr copied, tag=1.
- CANDPERM: writes perms = perms & operand[23:0] and copies the other fields. Never widens perms.
- CSEAL: key tag=0 → 1; key sealed → 2; key SEAL bit clear → 4; key cur outside [base, base+len) → 3. Writes attr = {key.cur[15:0], 7'b0, 1'b1} and copies the rest.
- CUNSEAL: src unsealed → 2; key checks as CSEAL with UNSEAL bit; src otype ≠ key.cur[15:0] → 6. Writes attr = 0 and copies the rest.
- CMOVE: copies all six fields, including tag.
- CCLRTAG: writes only tag=0.
- Op 7 → fault 5.
- On fault, no write enable asserts and the register file is untouched.
- src==dst and key==dst are legal, because results come from the snapshot.

## Timing
- Accept in cycle N (iw_req && ow_ready). READ at N+1, EXEC at N+2, COMMIT and ow_done at N+3. The write lands at the N+3 clock edge.
- Throughput: one op every 4 cycles. ow_ready=0 from N+1 to N+3.
- iw_req while busy is ignored: not queued, no effect.
- The op inputs need to be valid only in the accept cycle.
- Reset values:
  - State IDLE, ow_ready=1.
  - ow_done, ow_fault and every ow_wr_en_* = 0. ow_fault_code=0.
  - All addr and data outputs = 0, snapshots = 0.
- Reset in any state aborts the op. No write enable asserts in or after the reset cycle.
- Outputs are registered. Write enables are high in exactly one cycle per successful op.

## Configuration
- `CR_SEAL_EN` defined: CSEAL and CUNSEAL are implemented as above.
- `CR_SEAL_EN` undefined:
  - Ops 3 and 4 complete with fault 5 and no write.
  - Seal and otype logic and the rd2 snapshot registers are removed.
  - ow_rd_addr2 is tied to 0.

## Test plan
- CR1: base=100, len=50, cur=120, tag=1. CINC src=1, dst=2, operand=+30 → done at N+3, CR2.cur=150 written, no fault. Operand +31 → fault 3, no write.
- CSETBOUNDS on CR1 (cur=120) with operand=30 → base=120, len=30, tag=1. Operand=31 → fault 3. Operand=2^48-1 → fault 3 (carry).
- CANDPERM with perms=0x3F and mask 0x0C → perms=0x0C. Same op on a CR with tag=0 → fault 1.
- CSEAL with key cur=7 and SEAL set → attr=0x000701. CUNSEAL with key cur=8 → fault 6; key cur=7 → attr=0.
- Reset asserted in EXEC → no wr_en, ow_ready=1 next cycle. iw_req pulsed during READ → ignored, exactly one ow_done.
- Build without `CR_SEAL_EN`: CSEAL → fault 5, no write. Op 7 → fault 5 in both builds.

Source files
------------

// File: rtl/cr_op_seq.sv
// rtl/cr_op_seq.sv - multi-cycle capability-op sequencer for CR0..CR3
//
// Accepts one capability op every four cycles and walks it through
// IDLE -> READ -> EXEC -> COMMIT. READ snapshots the source (port 1) and key
// (port 2) CRs. EXEC evaluates the tag, seal, bounds and permission checks
// against that snapshot. COMMIT pulses ow_done and writes the result fields.
// A faulting op writes nothing.
//
// Ports:
//   iw_clk, iw_rst          clock, synchronous active-high reset
//   iw_req / ow_ready       op handshake; a request is taken only while idle
//   iw_op, iw_src, iw_key,  op code, CR indices and operand; these are
//   iw_dst, iw_operand      sampled only in the accept cycle
//   ow_rd_addr1/2, iw_rd1_* register-file read ports (src / key)
//   iw_rd2_*
//   ow_wr_*                 single field-wise register-file write port
//   ow_done, ow_fault,      completion pulse and fault report
//   ow_fault_code
//
// Build option CR_SEAL_EN: when it is defined, CSEAL and CUNSEAL are
// implemented. When it is undefined, ops 3 and 4 fault as illegal, the
// key-side snapshot is not built, and ow_rd_addr2 is held at 0.

`ifndef HBIT_ADDR
`define HBIT_ADDR 47
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif
`ifndef HBIT_TGT_CR
`define HBIT_TGT_CR 1
`endif

module cr_op_seq (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic                  iw_req,
  output logic                  ow_ready,
  input  logic [2:0]            iw_op,
  input  logic [`HBIT_TGT_CR:0] iw_src,
  input  logic [`HBIT_TGT_CR:0] iw_key,
  input  logic [`HBIT_TGT_CR:0] iw_dst,
  input  logic [`HBIT_ADDR:0]   iw_operand,
  output logic [`HBIT_TGT_CR:0] ow_rd_addr1,
  output logic [`HBIT_TGT_CR:0] ow_rd_addr2,
  input  logic [`HBIT_ADDR:0]   iw_rd1_base,
  input  logic [`HBIT_ADDR:0]   iw_rd1_len,
  input  logic [`HBIT_ADDR:0]   iw_rd1_cur,
  input  logic [`HBIT_DATA:0]   iw_rd1_perms,
  input  logic [`HBIT_DATA:0]   iw_rd1_attr,
  input  logic                  iw_rd1_tag,
  input  logic [`HBIT_ADDR:0]   iw_rd2_base,
  input  logic [`HBIT_ADDR:0]   iw_rd2_len,
  input  logic [`HBIT_ADDR:0]   iw_rd2_cur,
  input  logic [`HBIT_DATA:0]   iw_rd2_perms,
  input  logic [`HBIT_DATA:0]   iw_rd2_attr,
  input  logic                  iw_rd2_tag,
  output logic [`HBIT_TGT_CR:0] ow_wr_addr,
  output logic                  ow_wr_en_base,
  output logic                  ow_wr_en_len,
  output logic                  ow_wr_en_cur,
  output logic                  ow_wr_en_perms,
  output logic                  ow_wr_en_attr,
  output logic                  ow_wr_en_tag,
  output logic [`HBIT_ADDR:0]   ow_wr_base,
  output logic [`HBIT_ADDR:0]   ow_wr_len,
  output logic [`HBIT_ADDR:0]   ow_wr_cur,
  output logic [`HBIT_DATA:0]   ow_wr_perms,
  output logic [`HBIT_DATA:0]   ow_wr_attr,
  output logic                  ow_wr_tag,
  output logic                  ow_done,
  output logic                  ow_fault,
  output logic [2:0]            ow_fault_code
);

  localparam int AW = `HBIT_ADDR + 1;
  localparam int DW = `HBIT_DATA + 1;

  localparam logic [2:0] OP_CINC    = 3'd0;
  localparam logic [2:0] OP_CSETBND = 3'd1;
  localparam logic [2:0] OP_CANDPRM = 3'd2;
  localparam logic [2:0] OP_CSEAL   = 3'd3;
  localparam logic [2:0] OP_CUNSEAL = 3'd4;
  localparam logic [2:0] OP_CMOVE   = 3'd5;
  localparam logic [2:0] OP_CCLRTAG = 3'd6;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_TAG     = 3'd1;
  localparam logic [2:0] FC_SEALED  = 3'd2;
  localparam logic [2:0] FC_BOUNDS  = 3'd3;
  localparam logic [2:0] FC_PERM    = 3'd4;
  localparam logic [2:0] FC_ILLEGAL = 3'd5;
  localparam logic [2:0] FC_OTYPE   = 3'd6;

  // Write-enable vector order: {tag, attr, perms, cur, len, base}
  localparam logic [5:0] EN_CUR = 6'b000100;
  localparam logic [5:0] EN_TAG = 6'b100000;
  localparam logic [5:0] EN_ALL = 6'b111111;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_COMMIT} state_e;
  state_e state_q;

  logic [2:0]            op_q;
  logic [`HBIT_TGT_CR:0] dst_q;
  logic [AW-1:0]         opnd_q;

  logic [AW-1:0] s_base_q, s_len_q, s_cur_q;
  logic [DW-1:0] s_perms_q, s_attr_q;
  logic          s_tag_q;

  // Next-state results computed from the snapshot during EXEC
  logic [2:0]    code_d;
  logic [5:0]    en_d;
  logic [AW-1:0] base_d, len_d, cur_d;
  logic [DW-1:0] perms_d, attr_d;
  logic          tag_d;

  // Every bound is compared at AW+1 bits so that base+len cannot wrap
  logic [AW:0]   s_end;
  logic [AW-1:0] inc_cur;
  logic [AW:0]   sb_sum;
  assign s_end   = {1'b0, s_base_q} + {1'b0, s_len_q};
  assign inc_cur = s_cur_q + opnd_q;
  assign sb_sum  = {1'b0, s_cur_q} + {1'b0, opnd_q};

`ifdef CR_SEAL_EN
  logic [AW-1:0] k_base_q, k_len_q, k_cur_q;
  logic [DW-1:0] k_perms_q, k_attr_q;
  logic          k_tag_q;
  logic [AW:0]   k_end;
  logic          k_perm_bit;
  logic [2:0]    key_code;
  logic          unused_key_bits;

  assign k_end      = {1'b0, k_base_q} + {1'b0, k_len_q};
  // CSEAL needs the SEAL permission (bit 4); CUNSEAL needs UNSEAL (bit 5)
  assign k_perm_bit = (op_q == OP_CSEAL) ? k_perms_q[4] : k_perms_q[5];
  assign unused_key_bits = ^{k_perms_q[DW-1:6], k_perms_q[3:0], k_attr_q[DW-1:1]};

  // The key checks are shared by CSEAL and CUNSEAL. The key cursor must lie
  // in the half-open range [base, base+len).
  always_comb begin
    key_code = FC_NONE;
    if (!k_tag_q)                                          key_code = FC_TAG;
    else if (k_attr_q[0])                                  key_code = FC_SEALED;
    else if (!k_perm_bit)                                  key_code = FC_PERM;
    else if (k_cur_q < k_base_q || {1'b0, k_cur_q} >= k_end) key_code = FC_BOUNDS;
  end
`else
  logic unused_rd2;
  assign ow_rd_addr2 = '0;
  assign unused_rd2  = ^{iw_key, iw_rd2_base, iw_rd2_len, iw_rd2_cur,
                         iw_rd2_perms, iw_rd2_attr, iw_rd2_tag};
`endif

  always_comb begin
    code_d  = FC_NONE;
    en_d    = '0;
    base_d  = s_base_q;
    len_d   = s_len_q;
    cur_d   = s_cur_q;
    perms_d = s_perms_q;
    attr_d  = s_attr_q;
    tag_d   = s_tag_q;
    if (op_q != OP_CMOVE && op_q != OP_CCLRTAG && !s_tag_q) begin
      code_d = FC_TAG;
    end else if (op_q != OP_CMOVE && op_q != OP_CCLRTAG && op_q != OP_CUNSEAL
                 && s_attr_q[0]) begin
      code_d = FC_SEALED;
    end else begin
      case (op_q)
        OP_CINC: begin
          if (inc_cur < s_base_q || {1'b0, inc_cur} > s_end) begin
            code_d = FC_BOUNDS;
          end else begin
            cur_d = inc_cur;
            en_d  = EN_CUR;
          end
        end
        OP_CSETBND: begin
          // sb_sum[AW] is the carry out of cur+operand, which always faults
          if (s_cur_q < s_base_q || sb_sum[AW] || sb_sum > s_end) begin
            code_d = FC_BOUNDS;
          end else begin
            base_d = s_cur_q;
            len_d  = opnd_q;
            tag_d  = 1'b1;
            en_d   = EN_ALL;
          end
        end
        OP_CANDPRM: begin
          perms_d = s_perms_q & opnd_q[DW-1:0];
          en_d    = EN_ALL;
        end
`ifdef CR_SEAL_EN
        OP_CSEAL: begin
          if (key_code != FC_NONE) begin
            code_d = key_code;
          end else begin
            attr_d = {k_cur_q[15:0], 7'b0, 1'b1};
            en_d   = EN_ALL;
          end
        end
        OP_CUNSEAL: begin
          if (!s_attr_q[0])                          code_d = FC_SEALED;
          else if (key_code != FC_NONE)              code_d = key_code;
          else if (s_attr_q[DW-1:8] != k_cur_q[15:0]) code_d = FC_OTYPE;
          else begin
            attr_d = '0;
            en_d   = EN_ALL;
          end
        end
`endif
        OP_CMOVE: en_d = EN_ALL;
        OP_CCLRTAG: begin
          tag_d = 1'b0;
          en_d  = EN_TAG;
        end
        default: code_d = FC_ILLEGAL;
      endcase
    end
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_q        <= S_IDLE;
      ow_ready       <= 1'b1;
      op_q           <= '0;
      dst_q          <= '0;
      opnd_q         <= '0;
      ow_rd_addr1    <= '0;
      s_base_q       <= '0;
      s_len_q        <= '0;
      s_cur_q        <= '0;
      s_perms_q      <= '0;
      s_attr_q       <= '0;
      s_tag_q        <= 1'b0;
`ifdef CR_SEAL_EN
      ow_rd_addr2    <= '0;
      k_base_q       <= '0;
      k_len_q        <= '0;
      k_cur_q        <= '0;
      k_perms_q      <= '0;
      k_attr_q       <= '0;
      k_tag_q        <= 1'b0;
`endif
      ow_wr_addr     <= '0;
      ow_wr_en_base  <= 1'b0;
      ow_wr_en_len   <= 1'b0;
      ow_wr_en_cur   <= 1'b0;
      ow_wr_en_perms <= 1'b0;
      ow_wr_en_attr  <= 1'b0;
      ow_wr_en_tag   <= 1'b0;
      ow_wr_base     <= '0;
      ow_wr_len      <= '0;
      ow_wr_cur      <= '0;
      ow_wr_perms    <= '0;
      ow_wr_attr     <= '0;
      ow_wr_tag      <= 1'b0;
      ow_done        <= 1'b0;
      ow_fault       <= 1'b0;
      ow_fault_code  <= FC_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iw_req) begin
            op_q        <= iw_op;
            dst_q       <= iw_dst;
            opnd_q      <= iw_operand;
            ow_rd_addr1 <= iw_src;
`ifdef CR_SEAL_EN
            ow_rd_addr2 <= iw_key;
`endif
            ow_ready    <= 1'b0;
            state_q     <= S_READ;
          end
        end
        S_READ: begin
          s_base_q  <= iw_rd1_base;
          s_len_q   <= iw_rd1_len;
          s_cur_q   <= iw_rd1_cur;
          s_perms_q <= iw_rd1_perms;
          s_attr_q  <= iw_rd1_attr;
          s_tag_q   <= iw_rd1_tag;
`ifdef CR_SEAL_EN
          k_base_q  <= iw_rd2_base;
          k_len_q   <= iw_rd2_len;
          k_cur_q   <= iw_rd2_cur;
          k_perms_q <= iw_rd2_perms;
          k_attr_q  <= iw_rd2_attr;
          k_tag_q   <= iw_rd2_tag;
`endif
          state_q   <= S_EXEC;
        end
        S_EXEC: begin
          // Register results so that COMMIT presents them for exactly one cycle
          ow_done        <= 1'b1;
          ow_fault       <= (code_d != FC_NONE);
          ow_fault_code  <= code_d;
          ow_wr_addr     <= dst_q;
          ow_wr_en_base  <= (code_d == FC_NONE) & en_d[0];
          ow_wr_en_len   <= (code_d == FC_NONE) & en_d[1];
          ow_wr_en_cur   <= (code_d == FC_NONE) & en_d[2];
          ow_wr_en_perms <= (code_d == FC_NONE) & en_d[3];
          ow_wr_en_attr  <= (code_d == FC_NONE) & en_d[4];
          ow_wr_en_tag   <= (code_d == FC_NONE) & en_d[5];
          ow_wr_base     <= base_d;
          ow_wr_len      <= len_d;
          ow_wr_cur      <= cur_d;
          ow_wr_perms    <= perms_d;
          ow_wr_attr     <= attr_d;
          ow_wr_tag      <= tag_d;
          state_q        <= S_COMMIT;
        end
        default: begin
          ow_done        <= 1'b0;
          ow_fault       <= 1'b0;
          ow_fault_code  <= FC_NONE;
          ow_wr_en_base  <= 1'b0;
          ow_wr_en_len   <= 1'b0;
          ow_wr_en_cur   <= 1'b0;
          ow_wr_en_perms <= 1'b0;
          ow_wr_en_attr  <= 1'b0;
          ow_wr_en_tag   <= 1'b0;
          ow_ready       <= 1'b1;
          state_q        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cr_op_seq.sv
// tb/tb_cr_op_seq.sv - randomized self-checking bench for cr_op_seq
module tb_cr_op_seq;

  typedef struct packed {
    logic [47:0] base;
    logic [47:0] len;
    logic [47:0] cur;
    logic [23:0] perms;
    logic [23:0] attr;
    logic        tag;
  } cap_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, ready;
  logic [2:0]  op;
  logic [1:0]  src, key, dst, rd_addr1, rd_addr2, wr_addr;
  logic [47:0] operand;
  logic [47:0] rd1_base, rd1_len, rd1_cur, rd2_base, rd2_len, rd2_cur;
  logic [23:0] rd1_perms, rd1_attr, rd2_perms, rd2_attr;
  logic        rd1_tag, rd2_tag;
  logic        en_base, en_len, en_cur, en_perms, en_attr, en_tag;
  logic [47:0] wr_base, wr_len, wr_cur;
  logic [23:0] wr_perms, wr_attr;
  logic        wr_tag, done, fault;
  logic [2:0]  fault_code;

  // Environment register file (written by the DUT) and model register file
  logic [47:0] rf_base [4], rf_len [4], rf_cur [4];
  logic [23:0] rf_perms [4], rf_attr [4];
  logic        rf_tag [4];
  cap_t        mrf [4];

  int checks = 0;
  int errors = 0;

  // Expectation handed from the driver to the compare process
  logic       pend = 1'b0;
  logic       mon_en = 1'b0;
  int         cnt = 0;
  logic [2:0] e_code;
  logic [5:0] e_en;
  cap_t       e_cap;
  logic [1:0] e_dst;

  cr_op_seq dut (
    .iw_clk(clk), .iw_rst(rst), .iw_req(req), .ow_ready(ready),
    .iw_op(op), .iw_src(src), .iw_key(key), .iw_dst(dst), .iw_operand(operand),
    .ow_rd_addr1(rd_addr1), .ow_rd_addr2(rd_addr2),
    .iw_rd1_base(rd1_base), .iw_rd1_len(rd1_len), .iw_rd1_cur(rd1_cur),
    .iw_rd1_perms(rd1_perms), .iw_rd1_attr(rd1_attr), .iw_rd1_tag(rd1_tag),
    .iw_rd2_base(rd2_base), .iw_rd2_len(rd2_len), .iw_rd2_cur(rd2_cur),
    .iw_rd2_perms(rd2_perms), .iw_rd2_attr(rd2_attr), .iw_rd2_tag(rd2_tag),
    .ow_wr_addr(wr_addr),
    .ow_wr_en_base(en_base), .ow_wr_en_len(en_len), .ow_wr_en_cur(en_cur),
    .ow_wr_en_perms(en_perms), .ow_wr_en_attr(en_attr), .ow_wr_en_tag(en_tag),
    .ow_wr_base(wr_base), .ow_wr_len(wr_len), .ow_wr_cur(wr_cur),
    .ow_wr_perms(wr_perms), .ow_wr_attr(wr_attr), .ow_wr_tag(wr_tag),
    .ow_done(done), .ow_fault(fault), .ow_fault_code(fault_code)
  );

  assign rd1_base  = rf_base[rd_addr1];
  assign rd1_len   = rf_len[rd_addr1];
  assign rd1_cur   = rf_cur[rd_addr1];
  assign rd1_perms = rf_perms[rd_addr1];
  assign rd1_attr  = rf_attr[rd_addr1];
  assign rd1_tag   = rf_tag[rd_addr1];
  assign rd2_base  = rf_base[rd_addr2];
  assign rd2_len   = rf_len[rd_addr2];
  assign rd2_cur   = rf_cur[rd_addr2];
  assign rd2_perms = rf_perms[rd_addr2];
  assign rd2_attr  = rf_attr[rd_addr2];
  assign rd2_tag   = rf_tag[rd_addr2];

  always @(posedge clk) begin
    if (en_base)  rf_base[wr_addr]  = wr_base;
    if (en_len)   rf_len[wr_addr]   = wr_len;
    if (en_cur)   rf_cur[wr_addr]   = wr_cur;
    if (en_perms) rf_perms[wr_addr] = wr_perms;
    if (en_attr)  rf_attr[wr_addr]  = wr_attr;
    if (en_tag)   rf_tag[wr_addr]   = wr_tag;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_cap(input string name, input int idx, input cap_t act, input cap_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cr%0d actual=%h required=%h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Reference behaviour: the outcome of one op from the spec rules.
  // en order is {tag, attr, perms, cur, len, base}.
  function automatic void model(input logic [2:0] o, input cap_t s, input cap_t k,
                                input logic [47:0] opd, output logic [2:0] code,
                                output cap_t r, output logic [5:0] en);
    logic [48:0] s_end, k_end, sum;
    logic [47:0] nc;
    logic        seal_built, keyperm;
    r = s; en = 6'b0; code = 3'd0;
`ifdef CR_SEAL_EN
    seal_built = 1'b1;
`else
    seal_built = 1'b0;
`endif
    s_end = 49'(s.base) + 49'(s.len);
    k_end = 49'(k.base) + 49'(k.len);
    if (o != 3'd5 && o != 3'd6 && !s.tag) begin code = 3'd1; return; end
    if (o != 3'd5 && o != 3'd6 && o != 3'd4 && s.attr[0]) begin code = 3'd2; return; end
    if (o == 3'd7 || ((o == 3'd3 || o == 3'd4) && !seal_built)) begin code = 3'd5; return; end
    if (o == 3'd0) begin
      nc = s.cur + opd;
      if (49'(nc) < 49'(s.base) || 49'(nc) > s_end) code = 3'd3;
      else begin r.cur = nc; en = 6'b000100; end
    end else if (o == 3'd1) begin
      sum = 49'(s.cur) + 49'(opd);
      if (s.cur < s.base || sum > s_end || sum >= 49'h1_0000_0000_0000) code = 3'd3;
      else begin r.base = s.cur; r.len = opd; r.tag = 1'b1; en = 6'b111111; end
    end else if (o == 3'd2) begin
      r.perms = s.perms & opd[23:0]; en = 6'b111111;
    end else if (o == 3'd3 || o == 3'd4) begin
      if (o == 3'd4 && !s.attr[0]) begin code = 3'd2; return; end
      keyperm = (o == 3'd3) ? k.perms[4] : k.perms[5];
      if (!k.tag) code = 3'd1;
      else if (k.attr[0]) code = 3'd2;
      else if (!keyperm) code = 3'd4;
      else if (k.cur < k.base || 49'(k.cur) >= k_end) code = 3'd3;
      else if (o == 3'd4 && s.attr[23:8] != k.cur[15:0]) code = 3'd6;
      else begin
        r.attr = (o == 3'd3) ? {k.cur[15:0], 8'h01} : 24'h0;
        en = 6'b111111;
      end
    end else if (o == 3'd5) begin
      en = 6'b111111;
    end else begin
      r.tag = 1'b0; en = 6'b100000;
    end
  endfunction

  // Compare process: checks the DUT outputs on every cycle after reset
  always @(negedge clk) begin
    if (mon_en) begin
      if (pend) begin
        cnt++;
        if (cnt < 3) begin
          chk("busy_ready", ready, 0);
          chk("early_done", done, 0);
          chk("early_wren", {en_tag, en_attr, en_perms, en_cur, en_len, en_base}, 0);
        end else begin
          pend = 1'b0;
          chk("done", done, 1);
          chk("fault", fault, e_code != 3'd0);
          chk("fault_code", fault_code, e_code);
          chk("wr_en", {en_tag, en_attr, en_perms, en_cur, en_len, en_base}, e_en);
          if (e_en != 6'b0) chk("wr_addr", wr_addr, e_dst);
          if (e_en[0]) chk("wr_base", wr_base, e_cap.base);
          if (e_en[1]) chk("wr_len", wr_len, e_cap.len);
          if (e_en[2]) chk("wr_cur", wr_cur, e_cap.cur);
          if (e_en[3]) chk("wr_perms", wr_perms, e_cap.perms);
          if (e_en[4]) chk("wr_attr", wr_attr, e_cap.attr);
          if (e_en[5]) chk("wr_tag", wr_tag, e_cap.tag);
        end
      end else begin
        chk("idle_ready", ready, 1);
        chk("idle_done", done, 0);
        chk("idle_wren", {en_tag, en_attr, en_perms, en_cur, en_len, en_base}, 0);
      end
    end
  end

  task automatic set_cr(input int i, input logic [47:0] b, input logic [47:0] l,
                        input logic [47:0] c, input logic [23:0] p,
                        input logic [23:0] a, input logic t);
    rf_base[i] = b; rf_len[i] = l; rf_cur[i] = c;
    rf_perms[i] = p; rf_attr[i] = a; rf_tag[i] = t;
    mrf[i] = '{base: b, len: l, cur: c, perms: p, attr: a, tag: t};
  endtask

  task automatic rand_cr(input int i);
    logic [47:0] b, l, c;
    logic [23:0] p, a;
    b = ($urandom_range(0, 1) != 0) ? 48'($urandom_range(0, 1000)) : 48'd0;
    l = 48'($urandom_range(0, 300));
    c = b + 48'($urandom_range(0, 32'(l) + 4)) - 48'd2;
    p = 24'($urandom);
    a = {16'($urandom_range(0, 7)), 7'd0, 1'($urandom_range(0, 3) == 0)};
    set_cr(i, b, l, c, p, a, $urandom_range(0, 7) != 0);
  endtask

  task automatic scramble();
    op = 3'($urandom); src = 2'($urandom); key = 2'($urandom);
    dst = 2'($urandom); operand = {16'($urandom), 32'($urandom)};
  endtask

  task automatic cmp_rf();
    for (int i = 0; i < 4; i++)
      chk_cap("regfile", i, {rf_base[i], rf_len[i], rf_cur[i], rf_perms[i], rf_attr[i], rf_tag[i]}, mrf[i]);
  endtask

  // mode 0: plain op; 1: extra request pulsed during READ; 2: reset during EXEC
  task automatic run_op(input logic [2:0] o, input logic [1:0] s_i, input logic [1:0] k_i,
                        input logic [1:0] d_i, input logic [47:0] opd, input int mode,
                        output logic [2:0] code_o);
    cap_t       r;
    logic [5:0] en;
    logic [2:0] c;
    @(negedge clk); #1;
    model(o, mrf[s_i], mrf[k_i], opd, c, r, en);
    req = 1'b1; op = o; src = s_i; key = k_i; dst = d_i; operand = opd;
    @(posedge clk); #1;
    req = 1'b0; scramble();
    e_code = c; e_en = en; e_cap = r; e_dst = d_i; cnt = 0; pend = 1'b1;
    @(negedge clk); #1;
    if (mode == 1) begin req = 1'b1; scramble(); end
    @(negedge clk); #1;
    req = 1'b0;
    if (mode == 2) begin rst = 1'b1; pend = 1'b0; end
    @(negedge clk); #1;
    if (mode == 2) rst = 1'b0;
    @(posedge clk); #1;
    if (mode != 2 && c == 3'd0) begin
      if (en[0]) mrf[d_i].base  = r.base;
      if (en[1]) mrf[d_i].len   = r.len;
      if (en[2]) mrf[d_i].cur   = r.cur;
      if (en[3]) mrf[d_i].perms = r.perms;
      if (en[4]) mrf[d_i].attr  = r.attr;
      if (en[5]) mrf[d_i].tag   = r.tag;
    end
    code_o = (mode == 2) ? 3'd7 : c;
    cmp_rf();
    if (mode == 1) repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [2:0]  code;
    logic [47:0] opd;
    int          kk;
    rst = 1'b1; req = 1'b0; scramble();
    set_cr(0, 48'd0, 48'd0, 48'd0, 24'h0, 24'h0, 1'b0);
    set_cr(1, 48'd100, 48'd50, 48'd120, 24'h3F, 24'h0, 1'b1);
    set_cr(2, 48'd0, 48'd0, 48'd0, 24'h0, 24'h0, 1'b0);
    set_cr(3, 48'd0, 48'd0, 48'd0, 24'h0, 24'h0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_fault", {fault, fault_code}, 0);
    chk("rst_wren", {en_tag, en_attr, en_perms, en_cur, en_len, en_base}, 0);
    chk("rst_addrs", {rd_addr1, rd_addr2, wr_addr}, 0);
    chk("rst_data", {wr_base, wr_cur, wr_perms, wr_tag}, 0);
    #1 rst = 1'b0; mon_en = 1'b1;

    // CINC boundaries against literal results
    run_op(3'd0, 2'd1, 2'd0, 2'd2, 48'd30, 0, code);
    chk("cinc30_code", code, 0);
    chk("cinc30_cur", rf_cur[2], 48'd150);
    run_op(3'd0, 2'd1, 2'd0, 2'd2, 48'd31, 0, code);
    chk("cinc31_code", code, 3);
    chk("cinc31_cur", rf_cur[2], 48'd150);

    // CSETBOUNDS: fits, one past, carry out
    run_op(3'd1, 2'd1, 2'd0, 2'd3, 48'd30, 0, code);
    chk("sb30_code", code, 0);
    chk("sb30_fields", {rf_base[3], rf_len[3], rf_tag[3]}, {48'd120, 48'd30, 1'b1});
    run_op(3'd1, 2'd1, 2'd0, 2'd3, 48'd31, 0, code);
    chk("sb31_code", code, 3);
    run_op(3'd1, 2'd1, 2'd0, 2'd3, 48'hFFFF_FFFF_FFFF, 0, code);
    chk("sbmax_code", code, 3);

    // CANDPERM, then the same op on an untagged source
    run_op(3'd2, 2'd1, 2'd0, 2'd0, 48'h0C, 0, code);
    chk("andperm_perms", rf_perms[0], 24'h0C);
    set_cr(2, 48'd0, 48'd10, 48'd5, 24'h3F, 24'h0, 1'b0);
    run_op(3'd2, 2'd2, 2'd0, 2'd0, 48'h0C, 0, code);
    chk("andperm_notag", code, 1);

    // Sealing: key CR3 cur=7 with SEAL and UNSEAL permission
    set_cr(3, 48'd0, 48'd100, 48'd7, 24'h30, 24'h0, 1'b1);
    run_op(3'd3, 2'd1, 2'd3, 2'd2, 48'd0, 0, code);
`ifdef CR_SEAL_EN
    chk("cseal_attr", rf_attr[2], 24'h000701);
    set_cr(3, 48'd0, 48'd100, 48'd8, 24'h30, 24'h0, 1'b1);
    run_op(3'd4, 2'd2, 2'd3, 2'd0, 48'd0, 0, code);
    chk("cunseal_otype", code, 6);
    set_cr(3, 48'd0, 48'd100, 48'd7, 24'h30, 24'h0, 1'b1);
    run_op(3'd4, 2'd2, 2'd3, 2'd0, 48'd0, 0, code);
    chk("cunseal_attr", {code, rf_attr[0]}, 27'h0);
`else
    chk("cseal_off", code, 5);
`endif
    run_op(3'd7, 2'd1, 2'd0, 2'd0, 48'd0, 0, code);
    chk("illegal", code, 5);

    // Reset during EXEC and an extra request during READ
    run_op(3'd5, 2'd1, 2'd0, 2'd0, 48'd0, 2, code);
    run_op(3'd5, 2'd1, 2'd0, 2'd0, 48'd0, 1, code);
    chk("cmove_base", rf_base[0], 48'd100);

    for (int i = 0; i < 4; i++) rand_cr(i);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) rand_cr(int'($urandom_range(0, 3)));
      case ($urandom_range(0, 2))
        0: begin
          kk = int'($urandom_range(0, 80)) - 40;
          opd = {{16{kk[31]}}, kk};
        end
        1: opd = 48'($urandom_range(0, 320));
        default: opd = {16'($urandom), 32'($urandom)};
      endcase
      run_op(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), opd,
             ($urandom_range(0, 19) == 0) ? 1 : 0, code);
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
